// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline write-back (priority)
// and a one-entry buffer holding out-of-band long-latency results.
module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wb_we_i,
   input  logic [4:0]        wb_rd_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              mc_valid_i,
   input  logic [4:0]        mc_rd_i,
   input  logic [DATA_W-1:0] mc_data_i,
   output logic              mc_ready_o,
   output logic              stall_o,
   output logic              busy_o,
   output logic              rf_we_o,
   output logic [4:0]        rf_rd_o,
   output logic [DATA_W-1:0] rf_data_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HELD  = 2'd1,
      FORCE = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_MAX = 4'(STARVE_LIMIT - 1);

   state_t            state_r, state_nxt_s;
   logic [3:0]        wait_cnt_r, wait_cnt_nxt_s;
   logic [4:0]        buf_rd_r, buf_rd_nxt_s;
   logic [DATA_W-1:0] buf_data_r, buf_data_nxt_s;

   logic              wb_act_s;
   logic              mc_ready_s;
   logic              mc_fire_s;
   logic              stall_s;
   logic              rf_we_s;
   logic [4:0]        rf_rd_s;
   logic [DATA_W-1:0] rf_data_s;

   assign wb_act_s   = wb_we_i && (wb_rd_i != 5'd0);
   assign mc_ready_s = (state_r == IDLE) && !rst_i;
   assign mc_fire_s  = mc_valid_i && mc_ready_s;

   // State, wait counter and result buffer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         wait_cnt_r <= 4'd0;
         buf_rd_r   <= 5'd0;
         buf_data_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         buf_rd_r   <= buf_rd_nxt_s;
         buf_data_r <= buf_data_nxt_s;
      end
   end

   // Next-state and port mux; pipeline passes through unless the buffer owns the port.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      buf_rd_nxt_s   = buf_rd_r;
      buf_data_nxt_s = buf_data_r;
      stall_s        = 1'b0;
      rf_we_s        = wb_act_s;
      rf_rd_s        = wb_rd_i;
      rf_data_s      = wb_data_i;

      case (state_r)
         IDLE: begin
            if (mc_fire_s && (mc_rd_i != 5'd0)) begin
               buf_rd_nxt_s   = mc_rd_i;
               buf_data_nxt_s = mc_data_i;
               wait_cnt_nxt_s = 4'd0;
               state_nxt_s    = HELD;
            end else begin
               state_nxt_s    = IDLE;
            end
         end
         HELD: begin
            if (!wb_act_s) begin
               rf_we_s     = 1'b1;
               rf_rd_s     = buf_rd_r;
               rf_data_s   = buf_data_r;
               state_nxt_s = IDLE;
            end else if (wb_rd_i == buf_rd_r) begin
               // Younger pipeline write to the same register supersedes the buffer.
               state_nxt_s = IDLE;
            end else if (wait_cnt_r == WAIT_MAX) begin
               state_nxt_s = FORCE;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 4'd1;
            end
         end
         FORCE: begin
            stall_s     = 1'b1;
            rf_we_s     = 1'b1;
            rf_rd_s     = buf_rd_r;
            rf_data_s   = buf_data_r;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted.
   always_comb begin
      if (rst_i) begin
         mc_ready_o = 1'b0;
         stall_o    = 1'b0;
         busy_o     = 1'b0;
         rf_we_o    = 1'b0;
         rf_rd_o    = 5'd0;
         rf_data_o  = '0;
      end else begin
         mc_ready_o = mc_ready_s;
         stall_o    = stall_s;
         busy_o     = (state_r != IDLE);
         rf_we_o    = rf_we_s;
         rf_rd_o    = rf_rd_s;
         rf_data_o  = rf_data_s;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector-table and scoreboard bench for wb_port_arbiter (STARVE_LIMIT 4, plus a STARVE_LIMIT 1 instance).
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we, mc_valid;
   logic [4:0]  wb_rd, mc_rd;
   logic [31:0] wb_data, mc_data;
   logic        mc_ready, stall, busy, rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic        mc_ready1, stall1, busy1, rf_we1;
   logic [4:0]  rf_rd1;
   logic [31:0] rf_data1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.STARVE_LIMIT(4), .DATA_W(32)) u_dut (
      .clk_i(clk), .rst_i(rst), .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .mc_valid_i(mc_valid), .mc_rd_i(mc_rd), .mc_data_i(mc_data),
      .mc_ready_o(mc_ready), .stall_o(stall), .busy_o(busy),
      .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_data_o(rf_data));

   wb_port_arbiter #(.STARVE_LIMIT(1), .DATA_W(32)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .mc_valid_i(mc_valid), .mc_rd_i(mc_rd), .mc_data_i(mc_data),
      .mc_ready_o(mc_ready1), .stall_o(stall1), .busy_o(busy1),
      .rf_we_o(rf_we1), .rf_rd_o(rf_rd1), .rf_data_o(rf_data1));

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdata;
      logic        e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_stall;
      logic        e_busy;
      logic        e_rdy;
   } vec_t;

   typedef struct {
      int          idx;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        stall;
      logic        busy;
      logic        rdy;
   } exp_t;

   vec_t vecs[24];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      wb_we = we; wb_rd = rd; wb_data = d;
      mc_valid = mv; mc_rd = mrd; mc_data = md;
   endtask

   function automatic vec_t mk(input logic we, input logic [4:0] rd, input logic [31:0] d,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                               input logic es, input logic eb, input logic er);
      vec_t v;
      v.we = we; v.rd = rd; v.data = d; v.mv = mv; v.mrd = mrd; v.mdata = md;
      v.e_we = ewe; v.e_rd = erd; v.e_data = ed; v.e_stall = es; v.e_busy = eb; v.e_rdy = er;
      return v;
   endfunction

   initial begin
      // free port
      vecs[0]  = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[1]  = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      vecs[2]  = mk(1'b1, 5'd3, 32'h33,  1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,       1'b0, 1'b0, 1'b1);
      // starvation
      vecs[3]  = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[4]  = mk(1'b1, 5'd1, 32'h101, 1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'h101,      1'b0, 1'b1, 1'b0);
      vecs[5]  = mk(1'b1, 5'd2, 32'h102, 1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  32'h102,      1'b0, 1'b1, 1'b0);
      vecs[6]  = mk(1'b1, 5'd3, 32'h103, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h103,      1'b0, 1'b1, 1'b0);
      vecs[7]  = mk(1'b1, 5'd4, 32'h104, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h104,      1'b0, 1'b1, 1'b0);
      vecs[8]  = mk(1'b1, 5'd5, 32'h105, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,       1'b1, 1'b1, 1'b0);
      vecs[9]  = mk(1'b1, 5'd5, 32'h105, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h105,      1'b0, 1'b0, 1'b1);
      // same-rd conflict
      vecs[10] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd9,  32'h11,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[11] = mk(1'b1, 5'd9, 32'h22,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h22,       1'b0, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      // x0 handling
      vecs[13] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[14] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[15] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd10, 32'hA0,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[16] = mk(1'b1, 5'd0, 32'h99,  1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hA0,       1'b0, 1'b1, 1'b0);
      vecs[17] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      // backpressure: valid held with changing data
      vecs[18] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd12, 32'hC0,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[19] = mk(1'b1, 5'd1, 32'h201, 1'b1, 5'd13, 32'hC1,       1'b1, 5'd1,  32'h201,      1'b0, 1'b1, 1'b0);
      vecs[20] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd13, 32'hC2,       1'b1, 5'd12, 32'hC0,       1'b0, 1'b1, 1'b0);
      vecs[21] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd13, 32'hC3,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);
      vecs[22] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 32'hC3,       1'b0, 1'b1, 1'b0);
      vecs[23] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1);

      // reset: outputs quiet even with a valid result offered
      rst = 1'b1;
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h5);
      #12;
      n_vec++;
      chk("rst_ready", {31'd0, mc_ready}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_we",    {31'd0, rf_we}, 32'd0);
      chk("rst_rd",    {27'd0, rf_rd}, 32'd0);
      chk("rst_data",  rf_data, 32'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // table: push expectation on drive, pop and compare mid-cycle
      for (int i = 0; i < 24; i++) begin
         exp_t e;
         drive(vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].mv, vecs[i].mrd, vecs[i].mdata);
         e.idx = i; e.we = vecs[i].e_we; e.rd = vecs[i].e_rd; e.data = vecs[i].e_data;
         e.stall = vecs[i].e_stall; e.busy = vecs[i].e_busy; e.rdy = vecs[i].e_rdy;
         sb.push_back(e);
         #3;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty at vector %0d", i);
         end else begin
            exp_t x;
            x = sb.pop_front();
            n_vec++;
            chk($sformatf("v%0d_we", x.idx),    {31'd0, rf_we}, {31'd0, x.we});
            chk($sformatf("v%0d_rd", x.idx),    {27'd0, rf_rd}, {27'd0, x.rd});
            chk($sformatf("v%0d_data", x.idx),  rf_data, x.data);
            chk($sformatf("v%0d_stall", x.idx), {31'd0, stall}, {31'd0, x.stall});
            chk($sformatf("v%0d_busy", x.idx),  {31'd0, busy}, {31'd0, x.busy});
            chk($sformatf("v%0d_ready", x.idx), {31'd0, mc_ready}, {31'd0, x.rdy});
         end
         @(posedge clk); #1;
      end

      // STARVE_LIMIT=1 forces on the first busy cycle; then async reset during FORCE
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
      @(posedge clk); #1;
      drive(1'b1, 5'd1, 32'h301, 1'b0, 5'd0, 32'h0);
      #3;
      n_vec++;
      chk("l1_held_stall", {31'd0, stall1}, 32'd0);
      chk("l1_held_rd",    {27'd0, rf_rd1}, 32'd1);
      @(posedge clk); #1;
      #3;
      n_vec++;
      chk("l1_force_stall", {31'd0, stall1}, 32'd1);
      chk("l1_force_rd",    {27'd0, rf_rd1}, 32'd7);
      chk("l4_no_stall",    {31'd0, stall}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      #3;
      n_vec++;
      chk("l4_force_stall", {31'd0, stall}, 32'd1);
      chk("l4_force_rd",    {27'd0, rf_rd}, 32'd7);
      rst = 1'b1;
      #1;
      n_vec++;
      chk("async_stall", {31'd0, stall}, 32'd0);
      chk("async_we",    {31'd0, rf_we}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #3;
      n_vec++;
      chk("post_rst_ready", {31'd0, mc_ready}, 32'd1);
      chk("post_rst_busy",  {31'd0, busy}, 32'd0);
      chk("post_rst_we",    {31'd0, rf_we}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
